pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central pipeline sequencer for the 5-stage MIPS core. It merges the stall requests raised by IF, ID (load-use) and MEM (blocking IO input) into one per-stage stall vector and a flush strobe for the IF/ID register. It holds the pipeline frozen after reset until the program image has been loaded. It replaces ad-hoc per-register stall wiring between the stage registers, PC_reg and the button/UART front end.

## Interface
- `IO_TIMEOUT_CYCLES`, default 32'd100_000_000: IO-wait watchdog limit in clk cycles; used only with the macro.
- `STAT_W`, default 32: width of the stall-cycle statistics counter.

Ports:
- `clk` in 1: CPU clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `boot_done` in 1: level, high once the UART program load has finished (`upg_done`) or the start button has released the loader.
- `stall_req_if` in 1: instruction fetch not ready.
- `stall_req_id` in 1: load-use hazard in ID.
- `stall_req_io` in 1: MEM stage is executing a blocking IO input read.
- `enter` in 1: single-cycle debounced confirm pulse.
- `branch_taken` in 1: ID resolved a taken branch or jump this cycle.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- `flush_if_id` out 1: load a bubble into IF/ID.
- `io_ack` out 1: one-cycle strobe telling the IO module to latch the switch data.
- `stall_cycles` out STAT_W: saturating count of cycles with `stall[0]`=1 while in RUN or IO_WAIT.
- `busy_io` out 1: high while in IO_WAIT; drives the LED blink request.

## Operation
- FSM states: BOOT, RUN, IO_WAIT, IO_REL.
- BOOT: `stall`=6'b111111. Go to RUN on the first cycle with `boot_done`=1.
- RUN: `stall` is combinational, in priority order:
  - `stall_req_io` → 6'b011111, and go to IO_WAIT on the next edge.
  - otherwise `stall_req_id` → 6'b000111.
  - otherwise `stall_req_if` → 6'b000011.
  - otherwise 6'b000000.
- IO_WAIT: `stall`=6'b011111 (WB still retires).
  - `enter`=1 → go to IO_REL.
  - An `enter` pulse in the same cycle the FSM enters IO_WAIT (the RUN cycle that detects `stall_req_io`) is ignored.
- IO_REL: exactly one cycle.
  - `io_ack`=1; the MEM stage is released (stall computed as in RUN, ignoring `stall_req_io`).
  - Next state is RUN unconditionally.
  - `stall_req_io` seen high in the following RUN cycle is treated as a new instruction's request.
- `flush_if_id` = `branch_taken` & ~`stall[1]`. A branch raised during an ID stall is not flushed until the stall clears; ID holds `branch_taken` asserted meanwhile.
- `stall_cycles` increments by 1 per qualifying cycle and saturates at all-ones. It is never counted in BOOT.
- `busy_io` = (state == IO_WAIT).

## Timing
- Reset values: state BOOT, `stall`=6'b111111, `flush_if_id`=0, `io_ack`=0, `stall_cycles`=0, `busy_io`=0.
- `rst` mid-operation, including mid IO_WAIT, returns to BOOT immediately. `boot_done` must then be reasserted; a still-high level is accepted on the next edge.
- `stall` and `flush_if_id` are combinational from the registered state and the current requests: zero-cycle latency, no registered stall path.
- `io_ack` is registered-state decoded: asserted for exactly the one cycle spent in IO_REL, 1 cycle after the `enter` edge.
- Simultaneous `stall_req_io` and `stall_req_id` in RUN: the IO request wins and ID is held inside the 011111 mask.
- `enter` in RUN or IO_REL is dropped; there is no pending latch.

## Configuration
- `PIPE_STALL_IO_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to IO_WAIT and increments each cycle there.
  - On reaching `IO_TIMEOUT_CYCLES`-1 the FSM goes to IO_REL exactly as if `enter` had pulsed.
  - `enter` and timeout in the same cycle give a single IO_REL.
- Undefined: no counter; IO_WAIT waits indefinitely for `enter`.

## Structure
- The shared package holds:
  - the state enum (BOOT=2'd0, RUN=2'd1, IO_WAIT=2'd2, IO_REL=2'd3);
  - stall mask constants STALL_NONE, STALL_IF, STALL_ID, STALL_MEM, STALL_ALL;
  - the bit-index constants for the 6-bit vector.
- One sub-module, `sat_counter` (parameter width, inc, clr, value), used for `stall_cycles` and, with the macro, the IO timeout counter.

## Test plan
- Boot hold: reset, `boot_done`=0 for 20 cycles → `stall`=111111 and `stall_cycles`=0 throughout. Raise `boot_done` → `stall`=000000 on the next cycle.
- Load-use: in RUN, `stall_req_id`=1 for 1 cycle → `stall`=000111 that cycle and `stall_cycles` +1. Concurrent `branch_taken` gives `flush_if_id`=0 that cycle and 1 the next cycle.
- IO wait: `stall_req_io`=1 → `stall`=011111 and `busy_io`=1 for 50 cycles. `enter` pulse at cycle 50 → `io_ack`=1 for exactly one cycle, then RUN.
- Simultaneous requests: `stall_req_io`=`stall_req_id`=`stall_req_if`=1 → `stall`=011111. `enter` in the detecting cycle is ignored and IO_WAIT persists.
- Reset mid IO_WAIT: assert `rst` asynchronously → outputs return to reset values with no clock edge; `stall_cycles`=0.
- With `PIPE_STALL_IO_TIMEOUT_EN` and `IO_TIMEOUT_CYCLES`=16: no `enter` → `io_ack` after exactly 16 IO_WAIT cycles. Saturation check: force `stall_cycles` near all-ones → it holds at all-ones.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall sequencer: FSM state encoding,
// per-stage stall mask constants and the bit positions inside the 6-bit stall vector.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        IO_WAIT = 2'd2,
        IO_REL  = 2'd3
    } state_e;

    localparam int STALL_W = 6;

    localparam int STALL_BIT_PC      = 0;
    localparam int STALL_BIT_IF_ID   = 1;
    localparam int STALL_BIT_ID_EXE  = 2;
    localparam int STALL_BIT_EXE_MEM = 3;
    localparam int STALL_BIT_MEM_WB  = 4;
    localparam int STALL_BIT_WB      = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    // Request priority while the pipeline is running: IO read > load-use > fetch.
    function automatic logic [STALL_W-1:0] run_mask(input logic req_io,
                                                    input logic req_id,
                                                    input logic req_if);
        if (req_io)      return STALL_MEM;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall sequencer.
// master = pipeline / front-end side, slave = the sequencer.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STAT_W = 32
) ();

    logic               boot_done;
    logic               stall_req_if;
    logic               stall_req_id;
    logic               stall_req_io;
    logic               enter;
    logic               branch_taken;

    logic [STALL_W-1:0] stall;
    logic               flush_if_id;
    logic               io_ack;
    logic [STAT_W-1:0]  stall_cycles;
    logic               busy_io;

    modport master (
        output boot_done, stall_req_if, stall_req_id, stall_req_io, enter, branch_taken,
        input  stall, flush_if_id, io_ack, stall_cycles, busy_io
    );

    modport slave (
        input  boot_done, stall_req_if, stall_req_id, stall_req_io, enter, branch_taken,
        output stall, flush_if_id, io_ack, stall_cycles, busy_io
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Holds at all-ones once reached; value is the registered count.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer: merges IF/ID/IO stall requests into a per-stage hold vector
// (zero-cycle, combinational) and holds the core in BOOT until the image is loaded. Optional IO watchdog: PIPE_STALL_IO_TIMEOUT_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_TIMEOUT_CYCLES = 32'd100_000_000,
    parameter int          STAT_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    state_e             state_q;
    state_e             state_d;
    logic [STALL_W-1:0] stall_vec;
    logic               io_ack_c;
    logic               busy_io_c;
    logic               io_release;
    logic               io_timeout;
    logic               stat_inc;
    logic [STAT_W-1:0]  stat_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    assign io_release = bus.enter | io_timeout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (bus.boot_done)    state_d = RUN;
            RUN:     if (bus.stall_req_io) state_d = IO_WAIT;
            IO_WAIT: if (io_release)       state_d = IO_REL;
            IO_REL:                        state_d = RUN;
            default:                       state_d = BOOT;
        endcase
    end

    // IO_REL releases MEM for one cycle, so a still-high IO request is not honoured there.
    always_comb begin
        stall_vec = STALL_ALL;
        io_ack_c  = 1'b0;
        busy_io_c = 1'b0;
        case (state_q)
            BOOT: begin
                stall_vec = STALL_ALL;
            end
            RUN: begin
                stall_vec = run_mask(bus.stall_req_io, bus.stall_req_id, bus.stall_req_if);
            end
            IO_WAIT: begin
                stall_vec = STALL_MEM;
                busy_io_c = 1'b1;
            end
            IO_REL: begin
                stall_vec = run_mask(1'b0, bus.stall_req_id, bus.stall_req_if);
                io_ack_c  = 1'b1;
            end
            default: begin
                stall_vec = STALL_ALL;
            end
        endcase
    end

    assign stat_inc = stall_vec[STALL_BIT_PC] && ((state_q == RUN) || (state_q == IO_WAIT));

    sat_counter #(
        .WIDTH (STAT_W)
    ) u_stat_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stat_inc),
        .clr   (1'b0),
        .value (stat_val)
    );

`ifdef PIPE_STALL_IO_TIMEOUT_EN
    logic [31:0] io_wait_cnt;
    logic        io_wait_entry;

    assign io_wait_entry = (state_q != IO_WAIT) && (state_d == IO_WAIT);

    sat_counter #(
        .WIDTH (32)
    ) u_io_timeout (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == IO_WAIT),
        .clr   (io_wait_entry),
        .value (io_wait_cnt)
    );

    assign io_timeout = (state_q == IO_WAIT) && (io_wait_cnt == (IO_TIMEOUT_CYCLES - 32'd1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^IO_TIMEOUT_CYCLES;
    assign io_timeout         = 1'b0;
`endif

    // A branch seen while IF/ID is held is flushed once the hold clears; ID keeps it asserted.
    assign bus.stall        = stall_vec;
    assign bus.flush_if_id  = bus.branch_taken & ~stall_vec[STALL_BIT_IF_ID];
    assign bus.io_ack       = io_ack_c;
    assign bus.busy_io      = busy_io_c;
    assign bus.stall_cycles = stat_val;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    localparam int          SW   = 8;
    localparam int          CMAX = (1 << SW) - 1;
    localparam logic [31:0] TO   = 32'd16;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.STAT_W(SW)) bus ();

    pipe_stall_ctrl #(
        .IO_TIMEOUT_CYCLES (TO),
        .STAT_W            (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // inputs packed as {rst, boot_done, req_if, req_id, req_io, enter, branch}
    typedef struct {
        logic [6:0] in;
        logic [5:0] st;
        logic [2:0] fab;   // {flush_if_id, io_ack, busy_io}
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [20];

    bit m_booted, m_wait, m_rel;
    int m_wcnt, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        @(negedge clk);
        rst              = v[6];
        bus.boot_done    = v[5];
        bus.stall_req_if = v[4];
        bus.stall_req_id = v[3];
        bus.stall_req_io = v[2];
        bus.enter        = v[1];
        bus.branch_taken = v[0];
        #1;
    endtask

    task automatic check_out(input string tag, input logic [5:0] st, input logic fl,
                             input logic ack, input logic busy, input int cnt);
        chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
        chk({tag, ".flush"}, 32'(bus.flush_if_id), 32'(fl));
        chk({tag, ".ack"},   32'(bus.io_ack), 32'(ack));
        chk({tag, ".busy"},  32'(bus.busy_io), 32'(busy));
        chk({tag, ".cnt"},   32'(bus.stall_cycles), 32'(cnt));
    endtask

    initial begin
        logic [6:0] v;
        logic [5:0] es;
        int         n;
        int         nwait;
        bit         got;
        bit         to_hit;

        rst = 1'b1;
        bus.boot_done = 1'b0; bus.stall_req_if = 1'b0; bus.stall_req_id = 1'b0;
        bus.stall_req_io = 1'b0; bus.enter = 1'b0; bus.branch_taken = 1'b0;

        tbl[0]  = '{7'b1000000, 6'b111111, 3'b000, 8'd0};
        tbl[1]  = '{7'b0000001, 6'b111111, 3'b000, 8'd0};
        tbl[2]  = '{7'b0101000, 6'b111111, 3'b000, 8'd0};
        tbl[3]  = '{7'b0100000, 6'b000000, 3'b000, 8'd0};
        tbl[4]  = '{7'b0101001, 6'b000111, 3'b000, 8'd0};
        tbl[5]  = '{7'b0100001, 6'b000000, 3'b100, 8'd1};
        tbl[6]  = '{7'b0110000, 6'b000011, 3'b000, 8'd1};
        tbl[7]  = '{7'b0110001, 6'b000011, 3'b000, 8'd2};
        tbl[8]  = '{7'b0111110, 6'b011111, 3'b000, 8'd3};
        tbl[9]  = '{7'b0100000, 6'b011111, 3'b001, 8'd4};
        tbl[10] = '{7'b0100011, 6'b011111, 3'b001, 8'd5};
        tbl[11] = '{7'b0101101, 6'b000111, 3'b010, 8'd6};
        tbl[12] = '{7'b0100100, 6'b011111, 3'b000, 8'd6};
        tbl[13] = '{7'b0100010, 6'b011111, 3'b001, 8'd7};
        tbl[14] = '{7'b0100011, 6'b000000, 3'b110, 8'd8};
        tbl[15] = '{7'b0100010, 6'b000000, 3'b000, 8'd8};
        tbl[16] = '{7'b0100000, 6'b000000, 3'b000, 8'd8};
        tbl[17] = '{7'b1100000, 6'b111111, 3'b000, 8'd0};
        tbl[18] = '{7'b0100000, 6'b111111, 3'b000, 8'd0};
        tbl[19] = '{7'b0100000, 6'b000000, 3'b000, 8'd0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].in);
            check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].fab[2], tbl[i].fab[1],
                      tbl[i].fab[0], int'(tbl[i].cnt));
        end

        // boot hold: requests and branches are irrelevant until boot_done
        drive(7'b1000000);
        for (int i = 0; i < 20; i++) begin
            v = {2'b00, 5'($urandom)};
            drive(v);
            check_out($sformatf("boot%0d", i), 6'b111111, 1'b0, 1'b0, 1'b0, 0);
        end
        drive(7'b0100000);
        chk("boot.rise", 32'(bus.stall), 32'h3f);
        drive(7'b0100000);
        chk("boot.run", 32'(bus.stall), 32'h00);

        // IO wait
        drive(7'b0100100);
        check_out("io.detect", 6'b011111, 1'b0, 1'b0, 1'b0, 0);
`ifndef PIPE_STALL_IO_TIMEOUT_EN
        for (int i = 0; i < 49; i++) begin
            drive(7'b0100000);
            check_out($sformatf("io.wait%0d", i), 6'b011111, 1'b0, 1'b0, 1'b1, i + 1);
        end
        drive(7'b0100010);
        check_out("io.enter", 6'b011111, 1'b0, 1'b0, 1'b1, 50);
        drive(7'b0100000);
        check_out("io.rel", 6'b000000, 1'b0, 1'b1, 1'b0, 51);
        drive(7'b0100000);
        check_out("io.back", 6'b000000, 1'b0, 1'b0, 1'b0, 51);
`else
        nwait = 0;
        got   = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            drive(7'b0100000);
            if (bus.io_ack === 1'b1) got = 1'b1;
            else if (bus.busy_io === 1'b1) nwait++;
        end
        chk("timeout.seen", 32'(got), 32'd1);
        chk("timeout.cycles", 32'(nwait), 32'(TO));
`endif

        // asynchronous reset in the middle of IO_WAIT
        drive(7'b0100100);
        drive(7'b0100000);
        chk("arst.pre_busy", 32'(bus.busy_io), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_out("arst", 6'b111111, 1'b0, 1'b0, 1'b0, 0);
        drive(7'b1000000);

        // saturation of the statistics counter
        drive(7'b0100000);
        for (int i = 0; i < 300; i++) begin
            drive(7'b0101000);
            if (i >= 250) begin
                chk($sformatf("sat%0d", i), 32'(bus.stall_cycles),
                    32'((i < CMAX) ? i : CMAX));
            end
        end

        // randomized run against a behavioural model
        drive(7'b1000000);
        m_booted = 1'b0; m_wait = 1'b0; m_rel = 1'b0; m_wcnt = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            v[6] = ($urandom_range(0, 249) == 0);
            v[5] = ($urandom_range(0, 15) != 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 5) == 0);
            v[2] = ($urandom_range(0, 19) == 0);
            v[1] = ($urandom_range(0, 7) == 0);
            v[0] = ($urandom_range(0, 3) == 0);
            drive(v);
            if (v[6]) begin
                m_booted = 1'b0; m_wait = 1'b0; m_rel = 1'b0; m_wcnt = 0; m_cnt = 0;
            end
            if (!m_booted) begin
                es = 6'b111111;
            end else if (m_wait) begin
                es = 6'b011111;
            end else begin
                n  = (v[2] && !m_rel) ? 5 : v[3] ? 3 : v[4] ? 2 : 0;
                es = 6'((1 << n) - 1);
            end
            check_out($sformatf("rnd%0d", c), es, v[0] && !es[1], m_rel, m_wait, m_cnt);
            if (!v[6]) begin
                if (m_booted && !m_rel && es[0]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
`ifdef PIPE_STALL_IO_TIMEOUT_EN
                to_hit = (m_wcnt == int'(TO) - 1);
`else
                to_hit = 1'b0;
`endif
                if (!m_booted) begin
                    m_booted = v[5];
                end else if (m_rel) begin
                    m_rel = 1'b0;
                end else if (m_wait) begin
                    if (v[1] || to_hit) begin
                        m_wait = 1'b0;
                        m_rel  = 1'b1;
                    end else begin
                        m_wcnt++;
                    end
                end else if (v[2]) begin
                    m_wait = 1'b1;
                    m_wcnt = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
